// File: rtl/pipe_ctrl_n.sv
// rtl/pipe_ctrl_n.sv - pipeline stall/flush control with multi-cycle hold, stall counter and watchdog
module pipe_ctrl_n #(
   parameter int NSTAGES  = 5,
   parameter int MC_STAGE = 2,
   parameter int CW       = 6,
   parameter int WDOG     = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NSTAGES-1:0] stallreq,
   input  logic               mc_start,
   input  logic [CW-1:0]      mc_cycles,
   input  logic               excp_req,
   input  logic [31:0]        excp_pc,
   output logic [NSTAGES:0]   stall,
   output logic [NSTAGES:0]   flush,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic               mc_busy,
   output logic               mc_done,
   output logic [31:0]        stall_cnt,
   output logic               wdog_err
);

   logic [CW-1:0]      mc_cnt;
   logic               mc_hold;
   logic [NSTAGES-1:0] req;
   logic [NSTAGES:0]   stall_raw;

   // Multi-cycle hold is live on the start cycle and while the counter is still draining.
   always_comb begin
      mc_hold = (mc_start && (mc_cycles != '0)) || (mc_cnt != '0);
      req     = stallreq;
      if (mc_hold) begin
         req[MC_STAGE] = 1'b1;
      end
   end

   // Stage k-1 stalling freezes its own register and every register upstream of it.
   always_comb begin
      stall_raw    = '0;
      stall_raw[0] = |req;
      for (int k = 1; k <= NSTAGES; k++) begin
         stall_raw[k] = |(req >> (k - 1));
      end
   end

   // Output gating: reset silences everything, an exception flush overrides any stall.
   always_comb begin
      stall       = '0;
      flush       = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mc_busy     = 1'b0;
      mc_done     = 1'b0;
      if (!rst) begin
         if (excp_req) begin
            flush       = '1;
            redirect    = 1'b1;
            redirect_pc = excp_pc;
         end else begin
            stall = stall_raw;
         end
         mc_busy = mc_hold;
         mc_done = (mc_cnt == CW'(1)) ||
                   (mc_start && (mc_cycles == CW'(1)) && (mc_cnt == '0));
      end
   end

   // Remaining hold cycles after the current one; an exception aborts the op and blocks a new start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_cnt <= '0;
      end else if (excp_req) begin
         mc_cnt <= '0;
      end else if (mc_cnt != '0) begin
         mc_cnt <= mc_cnt - CW'(1);
      end else if (mc_start && (mc_cycles != '0)) begin
         mc_cnt <= mc_cycles - CW'(1);
      end
   end

   // Saturating count of cycles in which the PC register was held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   generate
      if (WDOG > 0) begin : g_wdog
         localparam logic [31:0] WDOG_LAST = 32'(WDOG - 1);
         logic [31:0] wdog_cnt;

         // Consecutive-stall watchdog; counter parks at its limit once the error is raised.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wdog_cnt <= '0;
               wdog_err <= 1'b0;
            end else if (!stall[0]) begin
               wdog_cnt <= '0;
            end else if (wdog_cnt == WDOG_LAST) begin
               wdog_err <= 1'b1;
            end else begin
               wdog_cnt <= wdog_cnt + 32'd1;
            end
         end
      end else begin : g_no_wdog
         // Watchdog disabled.
         always_comb begin
            wdog_err = 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb/tb_pipe_ctrl_n.sv - scoreboard bench for pipe_ctrl_n (NSTAGES=5, MC_STAGE=2, WDOG=8)
module tb_pipe_ctrl_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  stallreq = 5'h1F;
   logic        mc_start = 1'b0;
   logic [5:0]  mc_cycles = '0;
   logic        excp_req = 1'b0;
   logic [31:0] excp_pc = '0;
   logic [5:0]  stall, flush;
   logic        redirect, mc_busy, mc_done, wdog_err;
   logic [31:0] redirect_pc, stall_cnt;

   typedef struct {
      string       name;
      logic [5:0]  stall;
      logic [5:0]  flush;
      logic        redirect;
      logic [31:0] rpc;
      logic        busy;
      logic        done;
      logic        wdog;
      logic        chk_cnt;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   pipe_ctrl_n #(.NSTAGES(5), .MC_STAGE(2), .CW(6), .WDOG(8)) dut (
      .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start),
      .mc_cycles(mc_cycles), .excp_req(excp_req), .excp_pc(excp_pc),
      .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
      .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string vname, input string field, input logic [31:0] act,
                      input logic [31:0] expv);
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s.%s: got %h, expected %h", vname, field, act, expv);
      end
   endtask

   // Monitor: compares the DUT against the oldest pending expectation mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         chk(e.name, "stall", 32'(stall), 32'(e.stall));
         chk(e.name, "flush", 32'(flush), 32'(e.flush));
         chk(e.name, "redirect", 32'(redirect), 32'(e.redirect));
         chk(e.name, "redirect_pc", redirect_pc, e.rpc);
         chk(e.name, "mc_busy", 32'(mc_busy), 32'(e.busy));
         chk(e.name, "mc_done", 32'(mc_done), 32'(e.done));
         chk(e.name, "wdog_err", 32'(wdog_err), 32'(e.wdog));
         if (e.chk_cnt) begin
            chk(e.name, "stall_cnt", stall_cnt, e.cnt);
         end
      end
   end

   task automatic vec(input string name, input logic r, input logic [4:0] sreq,
                      input logic mcs, input logic [5:0] mcn, input logic ex,
                      input logic [31:0] pc, input logic [5:0] e_stall, input logic e_busy,
                      input logic e_done, input logic e_wdog, input logic chk_cnt,
                      input logic [31:0] e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; stallreq = sreq; mc_start = mcs; mc_cycles = mcn;
      excp_req = ex; excp_pc = pc;
      e.name     = name;
      e.stall    = e_stall;
      e.flush    = (ex && !r) ? 6'h3F : 6'h00;
      e.redirect = ex && !r;
      e.rpc      = (ex && !r) ? pc : 32'h0;
      e.busy     = e_busy;
      e.done     = e_done;
      e.wdog     = e_wdog;
      e.chk_cnt  = chk_cnt;
      e.cnt      = e_cnt;
      exp_q.push_back(e);
   endtask

   initial begin
      // reset with all requests raised, then release
      vec("rst0", 1, 5'h1F, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 0);
      vec("rst1", 1, 5'h1F, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 0);
      vec("rel",  0, 5'h1F, 0, 0, 0, 0, 6'h3F, 0, 0, 0, 1, 0);
      vec("ex",   0, 5'h04, 0, 0, 0, 0, 6'h0F, 0, 0, 0, 0, 0);
      vec("wb",   0, 5'h10, 0, 0, 0, 0, 6'h3F, 0, 0, 0, 0, 0);
      vec("id",   0, 5'h02, 0, 0, 0, 0, 6'h07, 0, 0, 0, 0, 0);
      vec("idle", 0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 4);
      // 4-cycle multi-cycle op, second start ignored
      vec("mc1",  0, 5'h00, 1, 4, 0, 0, 6'h0F, 1, 0, 0, 0, 0);
      vec("mc2",  0, 5'h00, 1, 2, 0, 0, 6'h0F, 1, 0, 0, 0, 0);
      vec("mc3",  0, 5'h00, 0, 0, 0, 0, 6'h0F, 1, 0, 0, 0, 0);
      vec("mc4",  0, 5'h00, 0, 0, 0, 0, 6'h0F, 1, 1, 0, 0, 0);
      vec("mc5",  0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 8);
      // N=0 and N=1
      vec("n0",   0, 5'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0);
      vec("n1",   0, 5'h00, 1, 1, 0, 0, 6'h0F, 1, 1, 0, 0, 0);
      vec("n1b",  0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 9);
      // exception aborts a hold in progress
      vec("xh1",  0, 5'h00, 1, 5, 0, 0, 6'h0F, 1, 0, 0, 0, 0);
      vec("xh2",  0, 5'h00, 0, 0, 1, 32'hBFC00380, 6'h00, 1, 0, 0, 0, 0);
      vec("xh3",  0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 10);
      // exception blocks a same-cycle start
      vec("xs1",  0, 5'h01, 1, 3, 1, 32'h80000180, 6'h00, 1, 0, 0, 0, 0);
      vec("xs2",  0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 10);
      // watchdog: 7 stalls, 1 free, 7 stalls never trips
      for (int i = 0; i < 7; i++) vec("w7a", 0, 5'h01, 0, 0, 0, 0, 6'h03, 0, 0, 0, 0, 0);
      vec("free", 0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 17);
      for (int i = 0; i < 7; i++) vec("w7b", 0, 5'h01, 0, 0, 0, 0, 6'h03, 0, 0, 0, 0, 0);
      vec("free2", 0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 24);
      // reset in the middle of a hold
      vec("rm1",  0, 5'h00, 1, 10, 0, 0, 6'h0F, 1, 0, 0, 0, 0);
      vec("rm2",  1, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 0);
      vec("rm3",  0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1, 0);
      // 10 stalled cycles: count to 10, watchdog trips after the 8th
      for (int i = 0; i < 10; i++)
         vec("s10", 0, 5'h01, 0, 0, 0, 0, 6'h03, 0, 0, (i >= 8), 0, 0);
      vec("s10e", 0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 1, 1, 10);
      // saturation
      vec("sat0", 0, 5'h01, 0, 0, 0, 0, 6'h03, 0, 0, 1, 0, 0);
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      vec("sat1", 0, 5'h01, 0, 0, 0, 0, 6'h03, 0, 0, 1, 1, 32'hFFFF_FFFF);
      vec("sat2", 0, 5'h01, 0, 0, 0, 0, 6'h03, 0, 0, 1, 1, 32'hFFFF_FFFF);
      vec("sat3", 0, 5'h00, 0, 0, 0, 0, 6'h00, 0, 0, 1, 1, 32'hFFFF_FFFF);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
